load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory port: accepts one load/store request at a time from the
//  pipeline MEM stage and drives a word-wide memory (mem_we/mem_addr/mem_wdata, combinational mem_rdata).
//  Performs byte/half extraction and sign/zero extension for loads. Performs read-modify-write
//  for SB/SH, because the memory has only a whole-word write enable.
// PARAMETERS
//  ADDRESS_WIDTH  32  byte-address width of req_addr and word-index width of mem_addr
//  DATA_WIDTH     32  data width; only 32 is supported
// PORTS
//  clk         in   1   clock; all state changes on posedge
//  rst         in   1   synchronous, active-high reset
//  req_valid   in   1   request present
//  req_ready   out  1   unit can accept (high only in IDLE)
//  req_we      in   1   1 = store, 0 = load
//  req_size    in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal
//  req_addr    in   AW  byte address
//  req_wdata   in   DW  store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid  out  1   one-cycle pulse, request complete
//  resp_rdata  out  DW  load result, extended; 0 for stores
//  resp_err    out  1   valid with resp_valid; misaligned access or illegal size
//  mem_we      out  1   word write enable to memory
//  mem_addr    out  AW  word index = {2'b00, addr[AW-1:2]}
//  mem_wdata   out  DW  word write data
//  mem_rdata   in   DW  word read data, combinational from mem_addr
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_we=0, mem_addr=0, mem_wdata=0.
//  - Handshake: accept when req_valid && req_ready. Register addr, size, we, wdata on accept.
//    req_ready=0 from the cycle after accept until return to IDLE. A req_valid asserted with req_ready low
//    is ignored, not queued.
//  - FSM states: IDLE, RD, WR, RESP.
//    IDLE -accept-> RD (load, or SB/SH) | WR (SW) | RESP (error, no memory access)
//    RD -> RESP (load: capture extended data) | WR (SB/SH: capture merged word)
//    WR -> RESP;  RESP -> IDLE (resp_valid=1 for exactly this cycle)
//  - Latency, counted from the accept edge: load 2 cycles, SW 2, SB/SH 3, error 1. Back-to-back request
//    can be accepted the cycle after RESP.
//  - mem_addr is held from the registered address in RD and WR; 0 in IDLE and RESP. mem_we=1 only in WR,
//    gated by !rst, so no write occurs in a cycle with rst high.
//  - Load extract: lane = addr[1:0]. B/BU take byte lane*8. H/HU take half addr[1]*16. B/H sign-extend;
//    BU/HU zero-extend; W passes the word through.
//  - SB merge: read word with byte lane replaced by wdata[7:0]. SH merge: half addr[1] replaced by
//    wdata[15:0]. Other bytes are preserved.
//  - Illegal size codes always yield resp_err=1 with no memory access.
//  - Reset mid-operation: the next state is IDLE and any pending write is dropped. No resp_valid is
//    issued for the aborted request.
//  - mem_addr wrap: the upper 2 bits are always 0. No bounds check against memory depth.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//    H/HU with addr[0]=1 and W with addr[1:0]!=0 are misaligned. They go IDLE->RESP with resp_err=1,
//    resp_rdata=0, and no mem_we.
//  MISALIGN_TRAP_EN undefined:
//    low address bits are forced aligned (H: addr[0]=0; W: addr[1:0]=0). resp_err is only for illegal size.
// TESTING
//  1 mem[0x4000]=0x8899AABB; LB addr 0x10002 -> resp_rdata=0xFFFFFF99 at accept+2, err=0, mem_we never 1
//  2 same word; LHU addr 0x10002 -> 0x00008899; LW 0x10000 -> 0x8899AABB; back-to-back accept after RESP
//  3 SB addr 0x10001 wdata 0x123456CC -> mem_we pulse at accept+2, mem[0x4000]=0x8899CCBB, resp at accept+3
//  4 SW addr 0x10004 wdata 0xDEADBEEF -> mem_we at accept+1 only; mem[0x4001]=0xDEADBEEF; resp_rdata=0
//  5 LW addr 0x10002: with MISALIGN_TRAP_EN -> resp_err=1 at accept+1, no mem access;
//    without -> reads mem[0x4000], err=0
//  6 rst high during WR of SB -> memory unchanged, no resp_valid, req_ready=1 next cycle;
//    req_size=011 -> resp_err=1

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory port.
//   Accepts one load/store at a time from the MEM stage, drives a word-wide memory
//   with a combinational read port, extracts and extends sub-word loads, and does
//   read-modify-write for SB/SH because the memory only has a whole-word write enable.
//   Optional feature: define MISALIGN_TRAP_EN to report misaligned H/HU/W accesses
//   as errors; otherwise the low address bits are forced aligned.
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   req_valid/req_ready                   request handshake (ready only in IDLE)
//   req_we, req_size, req_addr, req_wdata request payload (funct3 size code)
//   resp_valid, resp_rdata, resp_err      one-cycle completion pulse with result
//   mem_we, mem_addr, mem_wdata           word write port / word index
//   mem_rdata                             combinational word read data
module load_store_unit #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_size,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      lane_q, lane_d;
  logic [2:0]      size_q, size_d;
  logic            we_q, we_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [DW-1:0]   resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

  logic            size_legal_c;
  logic            misalign_c;
  logic [AW-1:0]   addr_al_c;
  logic [7:0]      byte_c;
  logic [15:0]     half_c;
  logic [DW-1:0]   load_c;
  logic [DW-1:0]   merge_c;

  // Legal funct3 size codes
  always_comb begin
    case (req_size)
      SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: size_legal_c = 1'b1;
      default:                        size_legal_c = 1'b0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  // Misaligned halfword/word accesses are reported instead of performed
  assign misalign_c = ((req_size[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  // Force the low address bits aligned for H and W (no-op when trapping)
  always_comb begin
    addr_al_c = req_addr;
    if (req_size[1:0] == 2'b01)      addr_al_c[0]   = 1'b0;
    else if (req_size[1:0] == 2'b10) addr_al_c[1:0] = 2'b00;
  end

  // Load lane extraction and extension from the word on the read port
  always_comb begin
    byte_c = mem_rdata[{lane_q, 3'b000} +: 8];
    half_c = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SZ_B:    load_c = {{24{byte_c[7]}}, byte_c};
      SZ_BU:   load_c = {24'h000000, byte_c};
      SZ_H:    load_c = {{16{half_c[15]}}, half_c};
      SZ_HU:   load_c = {16'h0000, half_c};
      default: load_c = mem_rdata;
    endcase
  end

  // SB/SH merge: store data was parked in mem_wdata_q at accept
  always_comb begin
    merge_c = mem_rdata;
    if (size_q[1:0] == 2'b00) merge_c[{lane_q, 3'b000} +: 8]     = mem_wdata_q[7:0];
    else                      merge_c[{lane_q[1], 4'b0000} +: 16] = mem_wdata_q[15:0];
  end

  // Next-state and next-output logic; all outputs are registered from these
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    size_d       = size_q;
    we_d         = we_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          lane_d      = addr_al_c[1:0];
          size_d      = req_size;
          we_d        = req_we;
          mem_wdata_d = req_wdata;
          if (!size_legal_c || misalign_c) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (req_we && (req_size == SZ_W)) begin
            state_d    = WR;
            mem_we_d   = 1'b1;
            mem_addr_d = {2'b00, addr_al_c[AW-1:2]};
          end else begin
            state_d    = RD;
            mem_addr_d = {2'b00, addr_al_c[AW-1:2]};
          end
        end
      end
      RD: begin
        if (we_q) begin
          state_d     = WR;
          mem_we_d    = 1'b1;
          mem_addr_d  = mem_addr_q;
          mem_wdata_d = merge_c;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_c;
        end
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lane_q       <= 2'b00;
      size_q       <= 3'b000;
      we_q         <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      we_q         <= we_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  // A reset arriving during WR must not let the pending write land
  assign mem_we     = mem_we_q & ~rst;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
